song_loader: RTL and testbench

- Upstream stage of the player: fills the off-chip SRAM with a song before the sequencer runs.
- Receives the song over a UART RX line (8N1) as big-endian 16-bit instruction words and writes them to SRAM from address 0 upward.
- Stops after the end instruction (bits [15:12]==0000) or after MAX_WORDS words, then releases the SRAM bus and asserts DONE.

---
 rtl/song_pkg.sv | 25 ++
 rtl/song_loader_uart_rx.sv | 72 +++++++
 rtl/song_loader.sv | 122 ++++++++++++
 tb/tb_song_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// song_pkg: shared constants, opcode helpers and loader state encoding for the song player.
package song_pkg;
    localparam logic [3:0] OP_END = 4'b0000;
    localparam logic [3:0] OP_BPM = 4'b0001;
    localparam int NOTE_BIT = 15;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam logic SRAM_INACTIVE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_HI, S_WAIT_LO, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_FINISHED
    } load_state_t;

    function automatic logic is_end(input logic [SRAM_DATA_W-1:0] word);
        return word[15:12] == OP_END;
    endfunction

    function automatic logic is_bpm(input logic [SRAM_DATA_W-1:0] word);
        return word[15:12] == OP_BPM;
    endfunction

    function automatic logic is_note(input logic [SRAM_DATA_W-1:0] word);
        return word[NOTE_BIT];
    endfunction
endpackage

// File: rtl/song_loader_uart_rx.sv
// uart_rx: 8N1 receiver with a two-flop synchronizer, mid-start-bit glitch rejection
// and stop-bit framing check; emits a one-cycle VALID or FRAME_ERR per frame.
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD = 115200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t r_state;
    logic [2:0] r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic w_rx;

    // r_sync[1] is the synchronized line, r_sync[2] its previous value for edge detection
    assign w_rx = r_sync[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RX_IDLE;
            r_sync <= 3'b111;
            r_cnt <= '0;
            r_bit <= '0;
            r_shift <= '0;
            DATA <= '0;
            VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], RX};
            VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_sync[2] && !w_rx) r_state <= RX_START;
                end
                RX_START: if (r_cnt == HALF) begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    r_state <= w_rx ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (r_cnt == FULL) begin
                    r_cnt <= '0;
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= RX_STOP;
                end
                RX_STOP: if (r_cnt == FULL) begin
                    r_state <= RX_IDLE;
                    DATA <= r_shift;
                    VALID <= w_rx;
                    FRAME_ERR <= !w_rx;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/song_loader.sv
// song_loader: receives big-endian 16-bit song words over UART and writes them to SRAM
// from address 0 until an end instruction or MAX_WORDS, then releases the bus.
module song_loader import song_pkg::*; #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD = 115200,
    parameter int MAX_WORDS = 262144
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   UART_RX,
    input  logic                   START,
    output logic                   SRAM_WE,
    output logic                   SRAM_CE,
    output logic                   SRAM_OE,
    output logic                   SRAM_LB,
    output logic                   SRAM_UB,
    output logic [SRAM_ADDR_W-1:0] SRAM_A,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_OUT,
    output logic                   SRAM_DQ_OE,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [SRAM_ADDR_W-1:0] WORD_COUNT,
    output logic                   ERR
);
    load_state_t r_state;
    logic r_pulse, r_we, r_ce, r_be, r_dq_oe, r_busy, r_done, r_err;
    logic [7:0] r_hi;
    logic [SRAM_ADDR_W-1:0] r_a, r_count;
    logic [SRAM_DATA_W-1:0] r_dq;
    logic [7:0] w_data;
    logic w_valid, w_frame_err, w_writing, w_full, w_last;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .CLK(CLK), .RST(RST), .RX(UART_RX),
        .DATA(w_data), .VALID(w_valid), .FRAME_ERR(w_frame_err)
    );

    assign w_writing = r_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    assign w_full = ({1'b0, r_count} + 19'd1) == 19'(MAX_WORDS);
    assign w_last = is_end(r_dq) || w_full;

    assign SRAM_WE = r_we;
    assign SRAM_CE = r_ce;
    assign SRAM_OE = SRAM_INACTIVE;
    assign SRAM_LB = r_be;
    assign SRAM_UB = r_be;
    assign SRAM_A = r_a;
    assign SRAM_DQ_OUT = r_dq;
    assign SRAM_DQ_OE = r_dq_oe;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign WORD_COUNT = r_count;
    assign ERR = r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pulse <= 1'b0;
            r_hi <= '0;
            r_we <= SRAM_INACTIVE;
            r_ce <= SRAM_INACTIVE;
            r_be <= SRAM_INACTIVE;
            r_a <= '0;
            r_dq <= '0;
            r_dq_oe <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_count <= '0;
            r_err <= 1'b0;
        end else if (START) begin
            r_state <= S_WAIT_HI;
            r_we <= SRAM_INACTIVE;
            r_ce <= SRAM_INACTIVE;
            r_be <= SRAM_INACTIVE;
            r_a <= '0;
            r_dq_oe <= 1'b0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_count <= '0;
            r_err <= 1'b0;
        end else begin
            // a byte arriving mid-write is an overrun and is dropped
            if (w_frame_err || (w_valid && w_writing)) r_err <= 1'b1;
            case (r_state)
                S_WAIT_HI: if (w_valid) begin
                    r_hi <= w_data;
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: if (w_valid) begin
                    r_ce <= 1'b0;
                    r_be <= 1'b0;
                    r_dq <= {r_hi, w_data};
                    r_dq_oe <= 1'b1;
                    r_state <= S_WR_SETUP;
                end
                S_WR_SETUP: begin
                    r_we <= 1'b0;
                    r_pulse <= 1'b0;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    r_pulse <= 1'b1;
                    if (r_pulse) begin
                        r_we <= SRAM_INACTIVE;
                        r_state <= S_WR_HOLD;
                    end
                end
                S_WR_HOLD: begin
                    r_dq_oe <= 1'b0;
                    r_ce <= SRAM_INACTIVE;
                    r_be <= SRAM_INACTIVE;
                    r_count <= r_count + 1'b1;
                    r_a <= w_full ? r_a : r_a + 1'b1;
                    r_state <= w_last ? S_FINISHED : S_WAIT_HI;
                    r_done <= w_last;
                    r_busy <= !w_last;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_song_loader.sv
// tb_song_loader: directed and randomized UART song loads, checked every cycle against a
// word-level model of the SRAM writes each load must produce.
module tb_song_loader;
    localparam int CLK_HZ = 1000, BAUD = 100, MAX = 4, CPB = CLK_HZ / BAUD;

    typedef struct packed { logic [17:0] a; logic [15:0] d; } wr_t;

    logic clk = 1'b0, rst = 1'b0, rx = 1'b1, start = 1'b0;
    logic sram_we, sram_ce, sram_oe, sram_lb, sram_ub, dq_oe, busy, done, err;
    logic [17:0] sram_a, word_count;
    logic [15:0] dq;

    int vectors = 0, fails = 0;
    wr_t exp_q[$];
    logic [15:0] wl[16];
    int wn = 0;
    logic [17:0] log_a[16];
    logic [15:0] log_d[16];
    int log_n = 0, writes_seen = 0;
    bit mon_en = 1'b0;

    logic p_we = 1'b1, p_ce = 1'b1, p_dq_oe = 1'b0;
    logic [17:0] p_a = '0, nxt_a = '0;
    logic [15:0] p_d = '0;
    int we_len = 0;
    bit hold_pend = 1'b0;

    song_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_WORDS(MAX)) dut (
        .CLK(clk), .RST(rst), .UART_RX(rx), .START(start),
        .SRAM_WE(sram_we), .SRAM_CE(sram_ce), .SRAM_OE(sram_oe),
        .SRAM_LB(sram_lb), .SRAM_UB(sram_ub), .SRAM_A(sram_a),
        .SRAM_DQ_OUT(dq), .SRAM_DQ_OE(dq_oe), .BUSY(busy), .DONE(done),
        .WORD_COUNT(word_count), .ERR(err)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.delete();
        writes_seen = 0;
        log_n = 0;
    endtask

    // Model: words land at 0,1,2.. until an end opcode or MAX words; everything after is ignored.
    task automatic run_load(input int bad_odds);
        int k;
        bit stop, e;
        k = 0;
        stop = 1'b0;
        e = 1'b0;
        for (int i = 0; i < wn; i++) begin
            if (!stop) begin
                exp_q.push_back({18'(k), wl[i]});
                k++;
                stop = (wl[i][15:12] == 4'h0) || (k == MAX);
            end
        end
        for (int i = 0; i < wn; i++) begin
            send_byte(wl[i][15:8], 1'b1);
            if (bad_odds > 0 && $urandom_range(1, bad_odds) == 1) begin
                send_byte(8'($urandom), 1'b0);
                idle(2 * CPB);
                e = 1'b1;
            end
            send_byte(wl[i][7:0], 1'b1);
        end
        idle(20);
        chk("load_done", 32'(done), 32'(stop));
        chk("load_busy", 32'(busy), 32'(!stop));
        chk("load_word_count", 32'(word_count), 32'(k));
        chk("load_err", 32'(err), 32'(e));
        chk("load_final_addr", 32'(sram_a), 32'(k == 0 ? 0 : (k == MAX ? k - 1 : k)));
        chk("load_writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            we_len = 0;
            hold_pend = 1'b0;
        end else begin
            chk("oe_high", 32'(sram_oe), 32'd1);
            if (!dq_oe) chk("ce_released", 32'(sram_ce), 32'd1);
            if (hold_pend) begin
                chk("post_dq_oe", 32'(dq_oe), 32'd0);
                chk("post_addr", 32'(sram_a), 32'(nxt_a));
                chk("post_count", 32'(word_count), 32'(writes_seen));
                hold_pend = 1'b0;
            end
            if (!sram_we) begin
                chk("we_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("we_ctrl", 32'({sram_ce, sram_lb, sram_ub, dq_oe}), 32'b0001);
                    chk("we_addr", 32'(sram_a), 32'(exp_q[0].a));
                    chk("we_data", 32'(dq), 32'(exp_q[0].d));
                    if (p_we) begin
                        chk("setup_ctrl", 32'({p_ce, p_dq_oe}), 32'b01);
                        chk("setup_addr", 32'(p_a), 32'(exp_q[0].a));
                        chk("setup_data", 32'(p_d), 32'(exp_q[0].d));
                    end
                end
                we_len++;
            end else if (!p_we) begin
                chk("we_width", 32'(we_len), 32'd2);
                if (exp_q.size() > 0) begin
                    chk("hold_dq_oe", 32'(dq_oe), 32'd1);
                    chk("hold_addr", 32'(sram_a), 32'(exp_q[0].a));
                    chk("hold_data", 32'(dq), 32'(exp_q[0].d));
                    if (log_n < 16) begin
                        log_a[log_n] = sram_a;
                        log_d[log_n] = dq;
                        log_n++;
                    end
                    writes_seen++;
                    nxt_a = (32'(exp_q[0].a) + 1 == MAX) ? exp_q[0].a : exp_q[0].a + 18'd1;
                    void'(exp_q.pop_front());
                    hold_pend = 1'b1;
                end
                we_len = 0;
            end
        end
        p_we = sram_we;
        p_ce = sram_ce;
        p_dq_oe = dq_oe;
        p_a = sram_a;
        p_d = dq;
    end

    initial begin
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({sram_we, sram_ce, sram_oe, sram_lb, sram_ub, dq_oe}), 32'b111110);
        chk("rst_addr", 32'(sram_a), 32'd0);
        chk("rst_data", 32'(dq), 32'd0);
        chk("rst_status", 32'({busy, done, err}), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        wl[0] = 16'h8015; wl[1] = 16'h1234; wl[2] = 16'h0000; wn = 3;
        run_load(0);
        chk("basic_log_n", 32'(log_n), 32'd3);
        chk("basic_w0", 32'({log_a[0], log_d[0]}), 32'({18'd0, 16'h8015}));
        chk("basic_w1", 32'({log_a[1], log_d[1]}), 32'({18'd1, 16'h1234}));
        chk("basic_w2", 32'({log_a[2], log_d[2]}), 32'({18'd2, 16'h0000}));
        chk("basic_done_count", 32'({done, err, word_count}), 32'({1'b1, 1'b0, 18'd3}));

        pulse_start();
        for (int i = 0; i < 5; i++) wl[i] = 16'h9001 + 16'(i);
        wn = 5;
        run_load(0);
        chk("max_log_n", 32'(log_n), 32'd4);
        chk("max_last_write", 32'({log_a[3], log_d[3]}), 32'({18'd3, 16'h9004}));
        chk("max_addr_held", 32'(sram_a), 32'd3);

        pulse_start();
        send_byte(8'h55, 1'b0);
        idle(2 * CPB);
        chk("frame_err_set", 32'(err), 32'd1);
        chk("frame_no_write", 32'(log_n), 32'd0);
        pulse_start();
        chk("frame_err_cleared", 32'(err), 32'd0);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * CPB);
        chk("glitch_no_err", 32'(err), 32'd0);
        chk("glitch_no_count", 32'(word_count), 32'd0);
        wl[0] = 16'hA0B1; wl[1] = 16'h0000; wn = 2;
        run_load(0);

        pulse_start();
        wl[0] = 16'h2222; wn = 1;
        run_load(0);
        pulse_start();
        wl[0] = 16'h3333; wn = 1;
        run_load(0);
        chk("restart_addr0", 32'({log_a[0], log_d[0]}), 32'({18'd0, 16'h3333}));
        chk("restart_count", 32'(word_count), 32'd1);

        // START lands on the cycle the low byte's rx_valid is seen by the loader
        pulse_start();
        send_byte(8'h11, 1'b1);
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (98) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        idle(10);
        chk("coinc_busy", 32'(busy), 32'd1);
        chk("coinc_addr", 32'(sram_a), 32'd0);
        chk("coinc_no_write", 32'(log_n), 32'd0);
        wl[0] = 16'h4567; wn = 1;
        run_load(0);

        for (int t = 0; t < 10; t++) begin
            pulse_start();
            wn = $urandom_range(1, 6);
            for (int i = 0; i < wn; i++) begin
                wl[i] = {($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), 12'($urandom)};
            end
            run_load(4);
        end

        pulse_start();
        wl[0] = 16'h1111; wn = 1;
        run_load(0);
        mon_en = 1'b0;
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        for (int c = 0; c < 20 && sram_we; c++) @(negedge clk);
        chk("rst_reached_pulse", 32'(sram_we), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({sram_we, sram_ce, dq_oe}), 32'b110);
        chk("rst_mid_status", 32'({busy, done}), 32'd0);
        chk("rst_mid_count", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
